seq_scan_controller: RTL and testbench

- Frame-level controller for a serial 8-bit pattern detector.
- Accepts parallel words from a host over a valid/ready handshake and serialises them MSB-first into the detector, one bit per stepped clock.
- Clears the detector at each frame start and counts its match pulses.
- Reports a per-frame summary: match count and position of the first match.

---
 rtl/seq_scan_pkg.sv | 13 +
 rtl/seq_scan_if.sv | 9 +
 rtl/seq_scan_serialiser.sv | 34 +++
 rtl/seq_scan_controller.sv | 110 +++++++++++
 tb/tb_seq_scan_controller.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/seq_scan_pkg.sv
// seq_scan_pkg: shared state encoding, default widths and saturating increment for the scan controller.
package seq_scan_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam int WORD_W_DEF  = 8;
  localparam int COUNT_W_DEF = 16;
  localparam int POS_W_DEF   = 16;
  // Works for widths up to 32; callers cast the result back to their own width.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
    logic [31:0] top;
    top = (w >= 32) ? '1 : (32'd1 << w) - 32'd1;
    return (v == top) ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/seq_scan_if.sv
// seq_scan_if: host word valid/ready handshake; the host drives master, the controller uses slave.
interface seq_scan_if import seq_scan_pkg::*; #(parameter int WORD_W = WORD_W_DEF);
  logic [WORD_W-1:0] word_in;
  logic              word_last;
  logic              word_valid;
  logic              word_ready;
  modport master(output word_in, word_last, word_valid, input word_ready);
  modport slave(input word_in, word_last, word_valid, output word_ready);
endinterface

// File: rtl/seq_scan_serialiser.sv
// seq_scan_serialiser: MSB-first shift register with a bit counter flagging the last bit of the loaded word.
module seq_scan_serialiser import seq_scan_pkg::*; #(
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic              clock,
  input  logic              nReset,
  input  logic              i_clear,
  input  logic              i_load,
  input  logic              i_shift,
  input  logic [WORD_W-1:0] i_word,
  output logic              o_bit,
  output logic              o_last_bit
);
  localparam int CNT_W = $clog2(WORD_W + 1);
  logic [WORD_W-1:0] r_sr;
  logic [CNT_W-1:0]  r_cnt;
  // Load wins over shift so the next word can replace the one finishing this cycle.
  always_ff @(posedge clock or negedge nReset)
    if (!nReset) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else if (i_clear) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_sr  <= i_word;
      r_cnt <= CNT_W'(WORD_W);
    end else if (i_shift) begin
      r_sr  <= {r_sr[WORD_W-2:0], 1'b0};
      r_cnt <= r_cnt - 1'b1;
    end
  assign o_bit      = r_sr[WORD_W-1];
  assign o_last_bit = r_cnt == CNT_W'(1);
endmodule

// File: rtl/seq_scan_controller.sv
// seq_scan_controller: frame controller feeding a serial pattern detector and summarising its matches.
// SEQ_SCAN_STOP_ON_MATCH_EN: stop stepping after the first match and drain the rest of the frame.
module seq_scan_controller import seq_scan_pkg::*; #(
  parameter int WORD_W  = WORD_W_DEF,
  parameter int COUNT_W = COUNT_W_DEF,
  parameter int POS_W   = POS_W_DEF
) (
  input  logic               clock,
  input  logic               nReset,
  seq_scan_if.slave          host,
  input  logic               abort,
  input  logic               match_in,
  output logic               bit_out,
  output logic               bit_step,
  output logic               det_clear,
  output logic               frame_done,
  output logic [COUNT_W-1:0] match_count,
  output logic               match_found,
  output logic [POS_W-1:0]   first_pos
);
`ifdef SEQ_SCAN_STOP_ON_MATCH_EN
  localparam bit STOP_ON_MATCH = 1'b1;
`else
  localparam bit STOP_ON_MATCH = 1'b0;
`endif
  state_t             r_state;
  logic               r_first, r_last, r_found;
  logic [COUNT_W-1:0] r_cnt, r_res_count;
  logic [POS_W-1:0]   r_pos, r_first_pos, r_res_first;
  logic               r_res_found;
  logic               w_last_bit, w_halt, w_end, w_accept, w_match, w_finish;
  logic [COUNT_W-1:0] w_cnt_nxt;
  logic [POS_W-1:0]   w_first_nxt;

  seq_scan_serialiser #(.WORD_W(WORD_W)) u_ser (
    .clock     (clock),
    .nReset    (nReset),
    .i_clear   (abort),
    .i_load    (w_accept),
    .i_shift   (bit_step),
    .i_word    (host.word_in),
    .o_bit     (bit_out),
    .o_last_bit(w_last_bit)
  );

  // Once halted, every SHIFT cycle is a word boundary so remaining words drain one per cycle.
  assign w_halt          = STOP_ON_MATCH & r_found;
  assign w_end           = w_last_bit | w_halt;
  assign bit_step        = (r_state == SHIFT) & ~w_halt;
  assign host.word_ready = nReset & ~abort & ((r_state == IDLE) | ((r_state == SHIFT) & w_end & ~r_last));
  assign w_accept        = host.word_valid & host.word_ready;
  assign det_clear       = w_accept & r_first;
  assign w_match         = match_in & bit_step;
  assign w_cnt_nxt       = w_match ? COUNT_W'(sat_inc(32'(r_cnt), COUNT_W)) : r_cnt;
  assign w_first_nxt     = (w_match & ~r_found) ? r_pos : r_first_pos;
  assign w_finish        = (r_state == SHIFT) & w_end & r_last;
  assign frame_done      = r_state == DONE;
  assign match_count     = r_res_count;
  assign match_found     = r_res_found;
  assign first_pos       = r_res_first;

  always_ff @(posedge clock or negedge nReset)
    if (!nReset) begin
      r_state     <= IDLE;
      r_first     <= 1'b1;
      r_last      <= 1'b0;
      r_found     <= 1'b0;
      r_cnt       <= '0;
      r_pos       <= '0;
      r_first_pos <= '0;
      r_res_count <= '0;
      r_res_found <= 1'b0;
      r_res_first <= '0;
    end else if (abort) begin
      r_state     <= IDLE;
      r_first     <= 1'b1;
      r_found     <= 1'b0;
      r_cnt       <= '0;
      r_pos       <= '0;
      r_first_pos <= '0;
    end else begin
      r_state <= (r_state == DONE) ? IDLE :
                 w_finish ? DONE :
                 w_accept ? SHIFT :
                 (r_state == SHIFT && w_end) ? IDLE : r_state;
      if (w_accept) begin
        r_last  <= host.word_last;
        r_first <= 1'b0;
      end
      if (bit_step) begin
        r_pos       <= POS_W'(sat_inc(32'(r_pos), POS_W));
        r_cnt       <= w_cnt_nxt;
        r_found     <= r_found | w_match;
        r_first_pos <= w_first_nxt;
      end
      // Results use next-state values so a match on the final bit is included.
      if (w_finish) begin
        r_res_count <= w_cnt_nxt;
        r_res_found <= r_found | w_match;
        r_res_first <= w_first_nxt;
      end
      if (r_state == DONE) begin
        r_first     <= 1'b1;
        r_found     <= 1'b0;
        r_cnt       <= '0;
        r_pos       <= '0;
        r_first_pos <= '0;
      end
    end
endmodule

// File: tb/tb_seq_scan_controller.sv
// tb_seq_scan_controller: table-driven frames plus abort/reset sequences against a 10110110 detector model.
module tb_seq_scan_controller;
  import seq_scan_pkg::*;
`ifdef SEQ_SCAN_STOP_ON_MATCH_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif
  typedef struct {
    logic [23:0] words;
    int n;
    int cnt;
    int cnt2;
    int found;
    int first;
    int steps;
  } vec_t;

  logic clock = 0, nReset = 0, abort = 0, match_in;
  logic bit_out, bit_step, det_clear, frame_done, match_found;
  logic bit_out2, bit_step2, det_clear2, frame_done2, match_found2;
  logic [15:0] match_count, first_pos, first_pos2;
  logic [1:0] match_count2;
  logic [7:0] hist = 8'h00;
  int tests = 0, fails = 0;
  int cyc = 0, steps = 0, steps2 = 0, dcs = 0, dcs2 = 0, dones = 0, runs = 0, last_step = 0, done_cyc = 0;
  logic prev_step = 0;
  logic [63:0] bits = '0;
  vec_t vecs[4];

  always #5 clock = ~clock;

  seq_scan_if #(.WORD_W(8)) hif ();
  seq_scan_if #(.WORD_W(8)) hif2 ();
  assign hif2.word_in    = hif.word_in;
  assign hif2.word_last  = hif.word_last;
  assign hif2.word_valid = hif.word_valid;

  seq_scan_controller #(.WORD_W(8), .COUNT_W(16), .POS_W(16)) dut (
    .clock(clock), .nReset(nReset), .host(hif), .abort(abort), .match_in(match_in),
    .bit_out(bit_out), .bit_step(bit_step), .det_clear(det_clear), .frame_done(frame_done),
    .match_count(match_count), .match_found(match_found), .first_pos(first_pos));

  seq_scan_controller #(.WORD_W(8), .COUNT_W(2), .POS_W(16)) dut2 (
    .clock(clock), .nReset(nReset), .host(hif2), .abort(abort), .match_in(match_in),
    .bit_out(bit_out2), .bit_step(bit_step2), .det_clear(det_clear2), .frame_done(frame_done2),
    .match_count(match_count2), .match_found(match_found2), .first_pos(first_pos2));

  // External detector: 10110110 with overlap, cleared by det_clear.
  assign match_in = bit_step & ({hist[6:0], bit_out} == 8'hB6);
  always @(posedge clock) begin
    if (det_clear) hist <= 8'h00;
    else if (bit_step) hist <= {hist[6:0], bit_out};
    cyc <= cyc + 1;
  end

  always @(negedge clock) begin
    prev_step <= bit_step;
    if (bit_step) begin
      steps     <= steps + 1;
      bits      <= {bits[62:0], bit_out};
      last_step <= cyc;
      if (!prev_step) runs <= runs + 1;
    end
    if (bit_step2) steps2 <= steps2 + 1;
    if (det_clear) dcs <= dcs + 1;
    if (det_clear2) dcs2 <= dcs2 + 1;
    if (frame_done) begin
      dones    <= dones + 1;
      done_cyc <= cyc;
    end
  end

  task automatic chk(input string nm, input longint got, input longint exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] w, input logic l);
    int t = 0;
    hif.word_in = w;
    hif.word_last = l;
    hif.word_valid = 1'b1;
    #1;
    while (!hif.word_ready && t < 60) begin
      @(negedge clock);
      #1;
      t++;
    end
    if (t >= 60) chk("send_timeout", t, 0);
    @(posedge clock);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int s0 = steps, s2 = steps2, d0 = dcs, d2 = dcs2, f0 = dones, r0 = runs, t = 0;
    longint mask;
    for (int i = 0; i < v.n; i++) send(8'(v.words >> (8 * (v.n - 1 - i))), i == v.n - 1);
    hif.word_valid = 1'b0;
    while (dones == f0 && t < 200) begin
      @(posedge clock);
      #1;
      t++;
    end
    chk({nm, ".done_timeout"}, t < 200, 1);
    repeat (3) @(posedge clock);
    #1;
    mask = (64'sd1 <<< v.steps) - 1;
    chk({nm, ".done_pulses"}, dones - f0, 1);
    chk({nm, ".count"}, match_count, v.cnt);
    chk({nm, ".found"}, match_found, v.found);
    chk({nm, ".first"}, first_pos, v.first);
    chk({nm, ".count_sat"}, match_count2, v.cnt2);
    chk({nm, ".found2"}, match_found2, v.found);
    chk({nm, ".first2"}, first_pos2, v.first);
    chk({nm, ".steps"}, steps - s0, v.steps);
    chk({nm, ".steps2"}, steps2 - s2, v.steps);
    chk({nm, ".runs"}, runs - r0, 1);
    chk({nm, ".bits"}, longint'(bits) & mask, (longint'(v.words) >>> (8 * v.n - v.steps)) & mask);
    chk({nm, ".det_clear"}, dcs - d0, 1);
    chk({nm, ".det_clear2"}, dcs2 - d2, 1);
    if (!STOP || v.n == 1) chk({nm, ".done_latency"}, done_cyc - last_step, 1);
  endtask

  initial begin
    int s0, f0;
    hif.word_in = '0;
    hif.word_last = 1'b0;
    hif.word_valid = 1'b0;
    vecs[0] = '{words: 24'h0000B6, n: 1, cnt: 1, cnt2: 1, found: 1, first: 7, steps: 8};
    vecs[1] = '{words: 24'h00B6DB, n: 2, cnt: STOP ? 1 : 3, cnt2: STOP ? 1 : 3, found: 1, first: 7,
                steps: STOP ? 8 : 16};
    vecs[2] = '{words: 24'h000000, n: 1, cnt: 0, cnt2: 0, found: 0, first: 0, steps: 8};
    vecs[3] = '{words: 24'hB6DB6F, n: 3, cnt: STOP ? 1 : 5, cnt2: STOP ? 1 : 3, found: 1, first: 7,
                steps: STOP ? 8 : 24};
    #12;
    chk("rst.word_ready", hif.word_ready, 0);
    chk("rst.bit_step", bit_step, 0);
    chk("rst.frame_done", frame_done, 0);
    chk("rst.count", match_count, 0);
    chk("rst.found", match_found, 0);
    chk("rst.first", first_pos, 0);
    chk("rst.bit_out", bit_out, 0);
    @(negedge clock);
    nReset = 1'b1;
    @(posedge clock);
    #1;
    chk("idle.word_ready", hif.word_ready, 1);

    for (int i = 0; i < 4; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // abort on the 4th bit of the second word
    f0 = dones;
    send(8'hB6, 1'b0);
    send(8'hDB, 1'b0);
    hif.word_valid = 1'b0;
    repeat (3) begin
      @(posedge clock);
      #1;
    end
    abort = 1'b1;
    @(posedge clock);
    #1;
    abort = 1'b0;
    s0 = steps;
    repeat (20) @(posedge clock);
    #1;
    chk("abort.no_done", dones - f0, 0);
    chk("abort.no_steps", steps - s0, 0);
    chk("abort.count_kept", match_count, vecs[3].cnt);
    chk("abort.count2_kept", match_count2, vecs[3].cnt2);
    chk("abort.first_kept", first_pos, 7);
    chk("abort.found_kept", match_found, 1);

    // abort wins over a same-cycle accept
    s0 = dcs;
    hif.word_in = 8'hB6;
    hif.word_last = 1'b1;
    hif.word_valid = 1'b1;
    abort = 1'b1;
    #1;
    chk("abort_vs_accept.ready", hif.word_ready, 0);
    @(posedge clock);
    #1;
    abort = 1'b0;
    hif.word_valid = 1'b0;
    #1;
    chk("abort_vs_accept.no_shift", bit_step, 0);
    chk("abort_vs_accept.no_clear", dcs - s0, 0);
    run_vec(vecs[0], "post_abort");

    // asynchronous reset in the middle of a frame
    send(8'hB6, 1'b1);
    hif.word_valid = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    nReset = 1'b0;
    #1;
    chk("midrst.bit_step", bit_step, 0);
    chk("midrst.word_ready", hif.word_ready, 0);
    chk("midrst.count", match_count, 0);
    chk("midrst.count2", match_count2, 0);
    chk("midrst.found", match_found, 0);
    chk("midrst.first", first_pos, 0);
    chk("midrst.frame_done", frame_done, 0);
    chk("midrst.bit_out", bit_out, 0);
    @(negedge clock);
    nReset = 1'b1;
    @(posedge clock);
    #1;
    run_vec(vecs[0], "post_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
